// File: rtl/kbd_event_seq.sv
// -----------------------------------------------------------------------------
// kbd_event_seq
//
// Pops scan-code bytes from the PS/2 receiver FIFO using a single-cycle,
// active-low pop strobe. It folds the E0 (extended) and F0 (break) prefixes
// into one key event and presents that event on a valid/ready interface.
// It also tracks the currently held key, counts accepted make events and
// keeps a sticky receiver-overflow flag.
//
// Build option:
//   KBD_TYPEMATIC_FILTER_EN - when defined, a make code that repeats the key
//                             already held is popped and dropped instead of
//                             being emitted (typematic repeat filter).
//
// Ports:
//   clk            clock
//   rst            synchronous reset, active low
//   fifo_ready     receiver FIFO holds at least one byte
//   fifo_data      byte at the FIFO head
//   fifo_overflow  receiver overflow indication
//   fifo_next_n    pop strobe, active low, one cycle per pop
//   evt_valid      key event available
//   evt_ready      consumer accepts the event
//   evt_code       scan code with prefixes stripped
//   evt_ext        event carried an E0 prefix
//   evt_break      event carried an F0 prefix (key release)
//   key_down       a key is currently held
//   press_count    accepted make events, wraps
//   ovf_sticky     receiver overflowed since reset
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | wait for a byte at the FIFO head (stalled once overflow seen)
// POP    | pop strobe low; classify the latched byte
// GAP    | one idle cycle so the FIFO head can advance
// EMIT   | event presented; wait for the consumer to accept it
// -----------------------------------------------------------------------------
module kbd_event_seq #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_ready,
    input  logic [7:0]         fifo_data,
    input  logic               fifo_overflow,
    output logic               fifo_next_n,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [7:0]         evt_code,
    output logic               evt_ext,
    output logic               evt_break,
    output logic               key_down,
    output logic [COUNT_W-1:0] press_count,
    output logic               ovf_sticky
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    localparam logic [7:0] B_EXT = 8'hE0;
    localparam logic [7:0] B_BRK = 8'hF0;
    localparam logic [7:0] B_NUL = 8'h00;

    logic [1:0] state;
    logic [7:0] byte_q;
    logic       ext_f;
    logic       brk_f;
    logic       emit_f;
    logic [8:0] held_q;
    logic       repeat_drop;

`ifdef KBD_TYPEMATIC_FILTER_EN
    // A make code for the key already held is an auto-repeat; swallow it.
    assign repeat_drop = !brk_f && key_down && ({ext_f, byte_q} == held_q);
`else
    assign repeat_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            byte_q      <= '0;
            ext_f       <= 1'b0;
            brk_f       <= 1'b0;
            emit_f      <= 1'b0;
            held_q      <= '0;
            fifo_next_n <= 1'b1;
            evt_valid   <= 1'b0;
            evt_code    <= '0;
            evt_ext     <= 1'b0;
            evt_break   <= 1'b0;
            key_down    <= 1'b0;
            press_count <= '0;
            ovf_sticky  <= 1'b0;
        end else begin
            // Strobe defaults high; only the IDLE->POP transition pulls it low,
            // so it can never be low on two consecutive cycles.
            fifo_next_n <= 1'b1;

            if (fifo_overflow) begin
                ovf_sticky <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (fifo_ready && !ovf_sticky) begin
                        byte_q      <= fifo_data;
                        fifo_next_n <= 1'b0;
                        state       <= S_POP;
                    end
                end

                S_POP: begin
                    state <= S_GAP;
                    case (byte_q)
                        B_EXT: ext_f <= 1'b1;
                        B_BRK: brk_f <= 1'b1;
                        B_NUL: begin
                        end
                        default: begin
                            if (repeat_drop) begin
                                ext_f <= 1'b0;
                                brk_f <= 1'b0;
                            end else begin
                                evt_code  <= byte_q;
                                evt_ext   <= ext_f;
                                evt_break <= brk_f;
                                emit_f    <= 1'b1;
                            end
                        end
                    endcase
                end

                S_GAP: begin
                    if (emit_f) begin
                        evt_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    // EMIT: evt_valid is high throughout, so evt_ready alone
                    // signals acceptance.
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        ext_f     <= 1'b0;
                        brk_f     <= 1'b0;
                        emit_f    <= 1'b0;
                        state     <= S_IDLE;
                        if (!evt_break) begin
                            held_q      <= {evt_ext, evt_code};
                            key_down    <= 1'b1;
                            press_count <= press_count + 1'b1;
                        end else if ({evt_ext, evt_code} == held_q) begin
                            key_down <= 1'b0;
                        end
                    end
                end
            endcase

            // Placed last so it wins over a prefix being set in POP on the
            // same cycle: a partial sequence cannot survive an overflow.
            if (fifo_overflow) begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kbd_event_seq.sv
module tb_kbd_event_seq;

   localparam int COUNT_W = 8;

   logic               clk;
   logic               rst;
   logic               fifo_ready;
   logic [7:0]         fifo_data;
   logic               fifo_overflow;
   logic               fifo_next_n;
   logic               evt_valid;
   logic               evt_ready;
   logic [7:0]         evt_code;
   logic               evt_ext;
   logic               evt_break;
   logic               key_down;
   logic [COUNT_W-1:0] press_count;
   logic               ovf_sticky;

   kbd_event_seq #(.COUNT_W(COUNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_ready    (fifo_ready),
      .fifo_data     (fifo_data),
      .fifo_overflow (fifo_overflow),
      .fifo_next_n   (fifo_next_n),
      .evt_valid     (evt_valid),
      .evt_ready     (evt_ready),
      .evt_code      (evt_code),
      .evt_ext       (evt_ext),
      .evt_break     (evt_break),
      .key_down      (key_down),
      .press_count   (press_count),
      .ovf_sticky    (ovf_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]         code;
      logic               ext;
      logic               brk;
      logic [COUNT_W-1:0] cnt;
      logic               down;
   } ev_t;

   int total = 0;
   int bad   = 0;

   logic [7:0] fq[$];
   ev_t        exq[$];

   logic               m_ext;
   logic               m_brk;
   logic [8:0]         m_held;
   logic               m_down;
   logic [COUNT_W-1:0] m_cnt;

   int         rdy_mode = 1;
   int         n_pops   = 0;
   int         n_events = 0;
   logic       s_low;
   logic       s_valid;
   logic       chk_pending = 1'b0;
   logic [COUNT_W-1:0] pend_cnt;
   logic       pend_down;
   logic       prev_hold = 1'b0;
   logic       prev_low  = 1'b0;
   logic [7:0] prev_code;
   logic       prev_ext;
   logic       prev_brk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic void model_reset();
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_held = '0;
      m_down = 1'b0;
      m_cnt  = '0;
   endfunction

   function automatic void push_byte(logic [7:0] b);
      ev_t e;
      bit  drop;
      fq.push_back(b);
      if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b != 8'h00) begin
         drop = 1'b0;
`ifdef KBD_TYPEMATIC_FILTER_EN
         drop = !m_brk && m_down && ({m_ext, b} == m_held);
`endif
         if (!drop) begin
            if (!m_brk) begin
               m_held = {m_ext, b};
               m_down = 1'b1;
               m_cnt  = m_cnt + 1'b1;
            end else if ({m_ext, b} == m_held) begin
               m_down = 1'b0;
            end
            e.code = b;
            e.ext  = m_ext;
            e.brk  = m_brk;
            e.cnt  = m_cnt;
            e.down = m_down;
            exq.push_back(e);
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   function automatic void drive_fifo();
      fifo_ready = (fq.size() != 0);
      fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
   endfunction

   task automatic step();
      ev_t e;
      bit  do_pop;
      @(negedge clk);
      case (rdy_mode)
         0:       evt_ready = ($urandom_range(0, 9) < 7);
         1:       evt_ready = 1'b1;
         default: evt_ready = 1'b0;
      endcase
      s_low   = (fifo_next_n === 1'b0);
      s_valid = (evt_valid === 1'b1);
      if (chk_pending) begin
         chk("press_count", press_count, pend_cnt);
         chk("key_down", key_down, pend_down);
         chk_pending = 1'b0;
      end
      if (prev_hold) begin
         chk("valid_held", evt_valid, 1'b1);
         chk("code_stable", evt_code, prev_code);
         chk("ext_stable", evt_ext, prev_ext);
         chk("brk_stable", evt_break, prev_brk);
      end
      if (prev_low) begin
         chk("strobe_single", fifo_next_n, 1'b1);
      end
      if (s_valid) begin
         chk("no_pop_in_emit", fifo_next_n, 1'b1);
      end
      do_pop = s_low;
      if (s_valid && evt_ready) begin
         n_events++;
         if (exq.size() == 0) begin
            chk("unexpected_event", {evt_ext, evt_break, evt_code}, 10'h3FF);
         end else begin
            e = exq.pop_front();
            chk("evt_code", evt_code, e.code);
            chk("evt_ext", evt_ext, e.ext);
            chk("evt_break", evt_break, e.brk);
            chk_pending = 1'b1;
            pend_cnt    = e.cnt;
            pend_down   = e.down;
         end
      end
      prev_hold = s_valid && !evt_ready;
      prev_low  = s_low;
      prev_code = evt_code;
      prev_ext  = evt_ext;
      prev_brk  = evt_break;
      @(posedge clk);
      #1;
      if (do_pop) begin
         n_pops++;
         if (fq.size() != 0) void'(fq.pop_front());
      end
      drive_fifo();
   endtask

   task automatic drain();
      int quiet = 0;
      for (int i = 0; i < 4000 && quiet < 5; i++) begin
         step();
         if (fq.size() == 0 && exq.size() == 0 && evt_valid !== 1'b1 && !chk_pending)
            quiet++;
         else
            quiet = 0;
      end
      chk("drain_events_left", exq.size(), 0);
      chk("drain_bytes_left", fq.size(), 0);
   endtask

   initial begin
      int first_low;
      int first_valid;
      int pops0;
      int ev0;
      int pushed;
      int r;
      logic [7:0] b;

      rst           = 1'b0;
      evt_ready     = 1'b0;
      fifo_overflow = 1'b0;
      model_reset();
      drive_fifo();

      for (int i = 0; i < 3; i++) step();
      chk("rst_next_n", fifo_next_n, 1'b1);
      chk("rst_valid", evt_valid, 1'b0);
      chk("rst_code", evt_code, 8'h00);
      chk("rst_ext", evt_ext, 1'b0);
      chk("rst_break", evt_break, 1'b0);
      chk("rst_key_down", key_down, 1'b0);
      chk("rst_count", press_count, 8'h00);
      chk("rst_ovf", ovf_sticky, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) step();

      rdy_mode    = 1;
      first_low   = -1;
      first_valid = -1;
      push_byte(8'h1C);
      drive_fifo();
      for (int k = 0; k < 8; k++) begin
         step();
         if (s_low && first_low < 0) first_low = k;
         if (s_valid && first_valid < 0) first_valid = k;
      end
      chk("lat1_strobe", first_low, 1);
      chk("lat1_valid", first_valid, 3);
      drain();
      chk("make_count", press_count, 8'd1);
      chk("make_down", key_down, 1'b1);

      push_byte(8'hF0);
      push_byte(8'h1C);
      drive_fifo();
      drain();
      chk("break_count", press_count, 8'd1);
      chk("break_down", key_down, 1'b0);

      pops0 = n_pops;
      push_byte(8'hE0);
      push_byte(8'h75);
      drive_fifo();
      drain();
      chk("ext_make_down", key_down, 1'b1);
      first_valid = -1;
      push_byte(8'hE0);
      push_byte(8'hF0);
      push_byte(8'h75);
      drive_fifo();
      for (int k = 0; k < 14; k++) begin
         step();
         if (s_valid && first_valid < 0) first_valid = k;
      end
      chk("lat3_valid", first_valid, 9);
      drain();
      chk("ext_break_down", key_down, 1'b0);
      chk("ext_pops", n_pops - pops0, 5);

      rdy_mode = 2;
      push_byte(8'h23);
      push_byte(8'h34);
      drive_fifo();
      for (int i = 0; i < 10 && evt_valid !== 1'b1; i++) step();
      chk("bp_wait_valid", evt_valid, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("bp_valid", evt_valid, 1'b1);
         chk("bp_code", evt_code, 8'h23);
         chk("bp_next_n", fifo_next_n, 1'b1);
      end
      rdy_mode = 1;
      drain();
      chk("bp_count", press_count, 8'd4);

      rdy_mode = 0;
      pops0    = n_pops;
      pushed   = 0;
      while (pushed < 200) begin
         if (fq.size() < 4 && $urandom_range(0, 2) != 0) begin
            r = $urandom_range(0, 9);
            case (r)
               0, 1:    b = 8'hE0;
               2, 3:    b = 8'hF0;
               4:       b = 8'h00;
               5, 6:    b = 8'h1C;
               7:       b = 8'h75;
               default: b = 8'($urandom_range(1, 8'hDF));
            endcase
            push_byte(b);
            drive_fifo();
            pushed++;
         end else begin
            step();
         end
      end
      drain();
      chk("rand_pops", n_pops - pops0, 200);
      chk("rand_count", press_count, m_cnt);
      chk("rand_down", key_down, m_down);

      rdy_mode = 1;
      fq.push_back(8'h1C);
      drive_fifo();
      for (int i = 0; i < 10 && fifo_next_n !== 1'b0; i++) step();
      chk("pop_seen", fifo_next_n, 1'b0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      model_reset();
      chk("mid_rst_next_n", fifo_next_n, 1'b1);
      chk("mid_rst_valid", evt_valid, 1'b0);
      chk("mid_rst_code", evt_code, 8'h00);
      chk("mid_rst_key_down", key_down, 1'b0);
      chk("mid_rst_count", press_count, 8'h00);
      chk("mid_rst_ovf", ovf_sticky, 1'b0);
      drain();

      ev0 = n_events;
      push_byte(8'h1C);
      push_byte(8'h1C);
      push_byte(8'h1C);
      drive_fifo();
      drain();
`ifdef KBD_TYPEMATIC_FILTER_EN
      chk("typ_events", n_events - ev0, 1);
      chk("typ_count", press_count, 8'd1);
`else
      chk("typ_events", n_events - ev0, 3);
      chk("typ_count", press_count, 8'd3);
`endif

      pops0 = n_pops;
      push_byte(8'hF0);
      drive_fifo();
      for (int i = 0; i < 10 && n_pops == pops0; i++) step();
      chk("ovf_prefix_popped", n_pops - pops0, 1);
      for (int i = 0; i < 3; i++) step();
      fifo_overflow = 1'b1;
      step();
      fifo_overflow = 1'b0;
      pops0 = n_pops;
      fq.push_back(8'h1C);
      drive_fifo();
      for (int i = 0; i < 20; i++) step();
      chk("ovf_sticky", ovf_sticky, 1'b1);
      chk("ovf_no_pops", n_pops - pops0, 0);
      chk("ovf_next_n", fifo_next_n, 1'b1);
      chk("ovf_valid", evt_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
